// File: rtl/lru_access_arbiter.sv
// Arbitrates fill and hit-update requests onto a shared LRU RAM, and sweeps every
// {set, way} through the access port after reset or flush to initialise the RAM.
//
// Handshake: a requester raises *_req with its operands and holds them stable until it
// sees *_gnt high in the same cycle; the grant is combinational, so the requester may
// drop or replace the request on the following edge.
module lru_access_arbiter #(
    parameter int NUM_SETS     = 64,
    parameter int NUM_WAYS     = 4,
    parameter int STARVE_LIMIT = 4,
    localparam int SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
    localparam int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush_req,
    output logic                       init_busy,

    input  logic                       fill_req,
    input  logic [SET_INDEX_WIDTH-1:0] fill_req_set,
    output logic                       fill_gnt,
    output logic                       fill_way_valid,
    output logic [WAY_INDEX_WIDTH-1:0] fill_way_out,

    input  logic                       acc_req,
    input  logic [SET_INDEX_WIDTH-1:0] acc_req_set,
    input  logic [WAY_INDEX_WIDTH-1:0] acc_req_way,
    output logic                       acc_gnt,

    output logic                       lru_fill_en,
    output logic [SET_INDEX_WIDTH-1:0] lru_fill_set,
    input  logic [WAY_INDEX_WIDTH-1:0] lru_fill_way,

    output logic                       lru_access_en,
    output logic [SET_INDEX_WIDTH-1:0] lru_access_set,
    output logic                       lru_update_en,
    output logic [WAY_INDEX_WIDTH-1:0] lru_update_way,

    output logic                       state_dbg
);

    localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SET_INDEX_WIDTH-1:0] SET_LAST  = SET_INDEX_WIDTH'(NUM_SETS - 1);
    localparam logic [WAY_INDEX_WIDTH-1:0] WAY_LAST  = WAY_INDEX_WIDTH'(NUM_WAYS - 1);
    localparam logic [STARVE_W-1:0]        STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                     state;
    logic [SET_INDEX_WIDTH-1:0] sweep_set;
    logic [WAY_INDEX_WIDTH-1:0] sweep_way;
    logic [STARVE_W-1:0]        starve_cnt;
    logic                       sweep_active;
    logic [WAY_INDEX_WIDTH-1:0] access_way;

    assign state_dbg = state;
    assign init_busy = (state == ST_INIT);
    assign fill_way_out = fill_way_valid ? lru_fill_way : '0;

    // The reset term keeps the sweep off the LRU port while reset is held.
    always_comb begin
        fill_gnt       = 1'b0;
        acc_gnt        = 1'b0;
        sweep_active   = reset && (state == ST_INIT);
        if (reset && (state == ST_RUN) && !flush_req) begin
            if (acc_req && (!fill_req || (starve_cnt == STARVE_MAX))) begin
                acc_gnt = 1'b1;
            end else if (fill_req) begin
                fill_gnt = 1'b1;
            end
        end
        lru_fill_en    = fill_gnt;
        lru_fill_set   = fill_gnt ? fill_req_set : '0;
        lru_access_en  = sweep_active || acc_gnt;
        lru_access_set = '0;
        access_way     = '0;
        if (sweep_active) begin
            lru_access_set = sweep_set;
            access_way     = sweep_way;
        end else if (acc_gnt) begin
            lru_access_set = acc_req_set;
            access_way     = acc_req_way;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_INIT;
            sweep_set      <= '0;
            sweep_way      <= '0;
            starve_cnt     <= '0;
            lru_update_en  <= 1'b0;
            lru_update_way <= '0;
            fill_way_valid <= 1'b0;
        end else begin
            lru_update_en  <= lru_access_en;
            lru_update_way <= access_way;
            fill_way_valid <= fill_gnt;

            if (acc_req && !acc_gnt) begin
                if (starve_cnt != STARVE_MAX) begin
                    starve_cnt <= starve_cnt + STARVE_W'(1);
                end
            end else begin
                starve_cnt <= '0;
            end

            // Flush wins over sweep progress in either state.
            if (flush_req) begin
                state     <= ST_INIT;
                sweep_set <= '0;
                sweep_way <= '0;
            end else if (state == ST_INIT) begin
                if (sweep_way == WAY_LAST) begin
                    sweep_way <= '0;
                    if (sweep_set == SET_LAST) begin
                        sweep_set <= '0;
                        state     <= ST_RUN;
                    end else begin
                        sweep_set <= sweep_set + SET_INDEX_WIDTH'(1);
                    end
                end else begin
                    sweep_way <= sweep_way + WAY_INDEX_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lru_access_arbiter.sv
// Bench for lru_access_arbiter: behavioural LRU RAM, cycle model of the arbiter rules,
// queue-driven requesters and directed scenarios with literal expectations.
module tb_lru_access_arbiter;

    localparam int NS = 64;
    localparam int NW = 4;
    localparam int SL = 4;
    localparam int SW = 6;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush_req = 1'b0;
    logic          init_busy;
    logic          fill_req = 1'b0;
    logic [SW-1:0] fill_req_set = '0;
    logic          fill_gnt;
    logic          fill_way_valid;
    logic [WW-1:0] fill_way_out;
    logic          acc_req = 1'b0;
    logic [SW-1:0] acc_req_set = '0;
    logic [WW-1:0] acc_req_way = '0;
    logic          acc_gnt;
    logic          lru_fill_en;
    logic [SW-1:0] lru_fill_set;
    logic [WW-1:0] lru_fill_way = '0;
    logic          lru_access_en;
    logic [SW-1:0] lru_access_set;
    logic          lru_update_en;
    logic [WW-1:0] lru_update_way;
    logic          state_dbg;

    lru_access_arbiter #(.NUM_SETS(NS), .NUM_WAYS(NW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .reset(reset), .flush_req(flush_req), .init_busy(init_busy),
        .fill_req(fill_req), .fill_req_set(fill_req_set), .fill_gnt(fill_gnt),
        .fill_way_valid(fill_way_valid), .fill_way_out(fill_way_out),
        .acc_req(acc_req), .acc_req_set(acc_req_set), .acc_req_way(acc_req_way),
        .acc_gnt(acc_gnt), .lru_fill_en(lru_fill_en), .lru_fill_set(lru_fill_set),
        .lru_fill_way(lru_fill_way), .lru_access_en(lru_access_en),
        .lru_access_set(lru_access_set), .lru_update_en(lru_update_en),
        .lru_update_way(lru_update_way), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural LRU RAM: per-way last-use stamps, victim is the oldest way.
    int            age [NS][NW];
    int            tick = 0;
    logic [SW-1:0] mem_upd_set = '0;

    function automatic logic [WW-1:0] victim(input logic [SW-1:0] s);
        int best = 0;
        for (int w = 1; w < NW; w++) begin
            if (age[s][w] < age[s][best]) best = w;
        end
        return WW'(best);
    endfunction

    always @(negedge clk) begin
        #2;
        tick++;
        if (lru_update_en) age[mem_upd_set][lru_update_way] = tick;
        if (lru_access_en) mem_upd_set = lru_access_set;
        if (lru_fill_en) lru_fill_way = victim(lru_fill_set);
    end

    // Requesters: each holds the head of its queue until granted.
    logic [SW-1:0]    fill_q[$];
    logic [SW+WW-1:0] acc_q[$];
    bit               fill_taken = 0;
    bit               acc_taken = 0;

    always @(posedge clk) begin
        #2;
        if (fill_taken && fill_q.size() > 0) void'(fill_q.pop_front());
        if (acc_taken && acc_q.size() > 0) void'(acc_q.pop_front());
        fill_taken = 0;
        acc_taken  = 0;
        fill_req     = (fill_q.size() > 0);
        fill_req_set = fill_req ? fill_q[0] : '0;
        acc_req      = (acc_q.size() > 0);
        {acc_req_set, acc_req_way} = acc_req ? acc_q[0] : '0;
    end

    // Arbiter model: sweep position as a flat pair index, plus pending-result flags.
    bit            m_sweep = 1;
    int            m_pos = 0;
    int            m_starve = 0;
    bit            m_upd_pend = 0;
    logic [WW-1:0] m_upd_way = '0;
    bit            m_fv = 0;

    int            cyc = 0;
    int            flush_cyc = 0;
    int            gl_code[$];
    int            gl_cyc[$];
    int            upd_log[$];
    int            last_fill_out = 7;
    int            fill_out_cnt = 0;

    always @(negedge clk) begin : compare
        logic          e_busy, e_fill, e_acc, e_aen, e_uen, e_fv;
        logic [SW-1:0] e_aset;
        logic [WW-1:0] e_way, e_uway, e_fwo;
        logic [22:0]   a, e;
        cyc++;
        e_busy = 1'b1; e_fill = 1'b0; e_acc = 1'b0; e_aen = 1'b0;
        e_aset = '0; e_way = '0; e_uen = 1'b0; e_uway = '0; e_fv = 1'b0; e_fwo = '0;
        if (reset) begin
            e_busy = m_sweep;
            if (m_sweep) begin
                e_aen  = 1'b1;
                e_aset = SW'(m_pos / NW);
                e_way  = WW'(m_pos % NW);
            end else if (!flush_req) begin
                if (acc_req && (!fill_req || m_starve == SL)) begin
                    e_acc = 1'b1; e_aen = 1'b1; e_aset = acc_req_set; e_way = acc_req_way;
                end else if (fill_req) begin
                    e_fill = 1'b1;
                end
            end
            e_uen  = m_upd_pend;
            e_uway = m_upd_pend ? m_upd_way : '0;
            e_fv   = m_fv;
            e_fwo  = m_fv ? lru_fill_way : '0;
        end
        e = {e_busy, e_fill, e_acc, e_fill, e_fill ? fill_req_set : SW'(0), e_aen, e_aset,
             e_uen, e_uway, e_fv, e_fwo};
        a = {init_busy, fill_gnt, acc_gnt, lru_fill_en, e_fill ? lru_fill_set : SW'(0),
             lru_access_en, e_aen ? lru_access_set : SW'(0), lru_update_en,
             e_uen ? lru_update_way : WW'(0), fill_way_valid, fill_way_out};
        check("cycle_outputs", 64'(a), 64'(e));

        fill_taken = fill_gnt;
        acc_taken  = acc_gnt;
        if (reset) begin
            if (fill_gnt) begin gl_code.push_back(1); gl_cyc.push_back(cyc); end
            if (acc_gnt) begin gl_code.push_back(2); gl_cyc.push_back(cyc); end
            if (flush_req) flush_cyc = cyc;
            if (lru_update_en && !init_busy) upd_log.push_back(int'(lru_update_way));
            if (fill_way_valid) begin last_fill_out = int'(fill_way_out); fill_out_cnt++; end
        end

        if (!reset) begin
            m_sweep = 1; m_pos = 0; m_starve = 0; m_upd_pend = 0; m_upd_way = '0; m_fv = 0;
        end else begin
            m_upd_pend = e_aen;
            m_upd_way  = e_way;
            m_fv       = e_fill;
            m_starve   = (acc_req && !e_acc) ? ((m_starve < SL) ? m_starve + 1 : SL) : 0;
            if (flush_req) begin
                m_sweep = 1; m_pos = 0;
            end else if (m_sweep) begin
                if (m_pos == NS * NW - 1) m_sweep = 0;
                else m_pos++;
            end
        end
    end

    task automatic wait_idle();
        int k = 0;
        while ((fill_q.size() > 0 || acc_q.size() > 0 || init_busy) && k < 3000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 3000) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: actual=%0d cycles expected<3000", k);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gl_code.delete();
        gl_cyc.delete();
        upd_log.delete();
        fill_out_cnt  = 0;
        last_fill_out = 7;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        int exp_codes[7];
        for (int s = 0; s < NS; s++) for (int w = 0; w < NW; w++) age[s][w] = 0;

        // Reset state and the initial sweep.
        repeat (2) @(negedge clk);
        check("reset_busy", init_busy, 1);
        check("reset_access_en", lru_access_en, 0);
        check("reset_update_en", lru_update_en, 0);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        n = 0;
        while (init_busy === 1'b1 && n < 2000) begin
            if (n == 0) check("sweep_first_set", lru_access_set, 0);
            if (n == 1) check("sweep_first_update", {lru_update_en, lru_update_way}, 3'b100);
            if (n == 5) check("sweep_pair5_set", lru_access_set, 1);
            if (n == 255) check("sweep_last_set", lru_access_set, 63);
            n++;
            @(negedge clk);
        end
        check("sweep_len", n, 256);
        check("first_run_update", {lru_update_en, lru_update_way}, 3'b111);

        @(posedge clk); #1; clear_logs(); fill_q.push_back(6'd5);
        wait_idle();
        check("fill_set5_count", fill_out_cnt, 1);
        check("fill_set5_victim", last_fill_out, 0);

        // Simultaneous fill and access: fill first, access next cycle.
        clear_logs();
        fill_q.push_back(6'd3); acc_q.push_back({6'd4, 2'd1});
        wait_idle();
        check("both_grants", gl_code.size(), 2);
        if (gl_code.size() == 2) begin
            check("both_first_fill", gl_code[0], 1);
            check("both_second_acc", gl_code[1], 2);
            check("both_back_to_back", gl_cyc[1] - gl_cyc[0], 1);
        end

        // Starvation: four fills, then the access, then fills resume.
        clear_logs();
        for (int i = 0; i < 6; i++) fill_q.push_back(SW'(10 + i));
        acc_q.push_back({6'd20, 2'd2});
        wait_idle();
        exp_codes = '{1, 1, 1, 1, 2, 1, 1};
        check("starve_grants", gl_code.size(), 7);
        if (gl_code.size() == 7) begin
            for (int i = 0; i < 7; i++) check($sformatf("starve_order_%0d", i), gl_code[i], exp_codes[i]);
            check("starve_span", gl_cyc[6] - gl_cyc[0], 6);
        end

        // Flush in RUN with a grant just before and requests pending.
        clear_logs();
        acc_q.push_back({6'd40, 2'd1});
        @(posedge clk); #1;
        flush_req = 1'b1;
        fill_q.push_back(6'd33); acc_q.push_back({6'd34, 2'd0});
        @(negedge clk);
        check("flush_no_grant", {fill_gnt, acc_gnt}, 0);
        check("flush_pending_update", {lru_update_en, lru_update_way}, 3'b101);
        @(posedge clk); #1; flush_req = 1'b0;
        @(negedge clk);
        check("flush_sweep_restart", {init_busy, lru_access_en, lru_access_set}, {2'b11, 6'd0});
        wait_idle();
        check("flush_grants", gl_code.size(), 3);
        if (gl_code.size() == 3) begin
            check("flush_pre_grant_cycle", flush_cyc - gl_cyc[0], 1);
            check("flush_gap", gl_cyc[1] - flush_cyc, 257);
            check("flush_starved_acc_first", gl_code[1], 2);
            check("flush_fill_after", gl_code[2], 1);
        end

        // Reset in the middle of a sweep at pair (30,2).
        @(posedge clk); #1; flush_req = 1'b1;
        @(posedge clk); #1; flush_req = 1'b0;
        repeat (122) @(posedge clk);
        #1;
        check("pre_reset_set", lru_access_set, 30);
        reset = 1'b0;
        @(negedge clk);
        check("mid_reset_outputs", {lru_access_en, lru_update_en, fill_way_valid, init_busy}, 4'b0001);
        repeat (2) @(posedge clk);
        #1; reset = 1'b1;
        @(negedge clk);
        check("post_reset_first", {lru_access_en, lru_access_set}, {1'b1, 6'd0});
        @(negedge clk);
        check("post_reset_update", {lru_update_en, lru_update_way}, 3'b100);
        wait_idle();

        // Back-to-back accesses to set 7, then victim lookups.
        clear_logs();
        acc_q.push_back({6'd7, 2'd1}); acc_q.push_back({6'd7, 2'd3});
        wait_idle();
        check("same_set_updates", upd_log.size(), 2);
        if (upd_log.size() == 2) begin
            check("same_set_way_a", upd_log[0], 1);
            check("same_set_way_b", upd_log[1], 3);
        end
        clear_logs(); fill_q.push_back(6'd7);
        wait_idle();
        check("fill_set7_victim", last_fill_out, 0);
        acc_q.push_back({6'd9, 2'd0});
        wait_idle();
        clear_logs(); fill_q.push_back(6'd9);
        wait_idle();
        check("fill_set9_count", fill_out_cnt, 1);
        check("fill_set9_victim", last_fill_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lru_access_arbiter.md
LRU_ACCESS_ARBITER -- requirements
Module: lru_access_arbiter

Interface
REQ-001: Parameter NUM_SETS, default 64, number of LRU sets.
REQ-002: Parameter NUM_WAYS, default 4, ways per set; legal values 1, 2, 4, 8.
REQ-003: Parameter STARVE_LIMIT, default 4, consecutive denied access cycles before access gets priority.
REQ-004: Derived widths SET_INDEX_WIDTH = $clog2(NUM_SETS) and WAY_INDEX_WIDTH = $clog2(NUM_WAYS) SHALL be used for all set and way ports.
REQ-005: clk  in  1  single clock; all state on its rising edge.
REQ-006: reset  in  1  asynchronous, active-low reset.
REQ-007: flush_req  in  1  one-cycle pulse; restarts the init sweep.
REQ-008: init_busy  out  1  high while the init sweep runs.
REQ-009: fill_req, fill_req_set  in  1, SET_INDEX_WIDTH  fill requester; held until granted.
REQ-010: fill_gnt  out  1  fill granted this cycle.
REQ-011: fill_way_valid, fill_way_out  out  1, WAY_INDEX_WIDTH  victim way, returned the cycle after fill_gnt.
REQ-012: acc_req, acc_req_set, acc_req_way  in  1, SET_INDEX_WIDTH, WAY_INDEX_WIDTH  hit-update requester; held until granted.
REQ-013: acc_gnt  out  1  access granted this cycle.
REQ-014: lru_fill_en, lru_fill_set  out  1, SET_INDEX_WIDTH  to LRU fill port.
REQ-015: lru_fill_way  in  WAY_INDEX_WIDTH  LRU victim, valid the cycle after lru_fill_en.
REQ-016: lru_access_en, lru_access_set  out  1, SET_INDEX_WIDTH  to LRU access port.
REQ-017: lru_update_en, lru_update_way  out  1, WAY_INDEX_WIDTH  to LRU update port; asserted the cycle after lru_access_en.

Function
REQ-018: The FSM SHALL have two states: INIT (sweep) and RUN.
REQ-019: INIT: one LRU access per cycle with sweep counter {set, way}: lru_access_set = set, way 0..NUM_WAYS-1 per set, sets 0..NUM_SETS-1 ascending.
REQ-020: INIT SHALL last exactly NUM_SETS*NUM_WAYS cycles; after the last pair it SHALL enter RUN on the next edge.
REQ-021: Every lru_access_en cycle (sweep or grant) SHALL register the way and assert lru_update_en with that way the following cycle, including the first RUN cycle.
REQ-022: In INIT: fill_gnt = acc_gnt = lru_fill_en = 0; init_busy = 1.
REQ-023: In RUN at most one grant per cycle; grants are combinational in the request cycle.
REQ-024: Grant: fill_gnt drives lru_fill_en/lru_fill_set; acc_gnt drives lru_access_en/lru_access_set.
REQ-025: Priority: fill over access, except when starve_cnt == STARVE_LIMIT, in which case access wins.
REQ-026: starve_cnt increments when acc_req=1 and acc_gnt=0; it saturates at STARVE_LIMIT and clears on acc_gnt or when acc_req=0.
REQ-027: The cycle after fill_gnt: fill_way_valid = 1 and fill_way_out = lru_fill_way; otherwise fill_way_valid = 0 and fill_way_out = 0.
REQ-028: flush_req in RUN SHALL enter INIT at {0,0} on the next edge with no grant that cycle; flush_req in INIT SHALL restart the sweep at {0,0}.
REQ-029: A pending update or fill_way_valid from a grant in the flush cycle's predecessor SHALL still complete.
REQ-030: Back-to-back accesses to the same set are legal; no stall is inserted because the LRU RAM resolves read-during-write.

Reset
REQ-031: While reset = 0: state = INIT, sweep counter = {0,0}, starve_cnt = 0, pending update cleared, fill_way_valid = 0, all grant and LRU enable outputs = 0, init_busy = 1.
REQ-032: Reset asserted mid-operation SHALL abandon the sweep or any pending update immediately; after release the sweep starts at {0,0} in the first cycle.

Verification
REQ-033: Reset release (64 sets, 4 ways) -> init_busy high 256 cycles, access pairs (0,0),(0,1)...(63,3), updates lag by 1; then a fill on set 5 returns fill_way_out = 0.
REQ-034: fill_req and acc_req in the same RUN cycle -> fill_gnt that cycle, acc_gnt the next cycle.
REQ-035: fill_req held high continuously with acc_req high -> four fill grants, acc_gnt in the 5th cycle, then fill grants resume.
REQ-036: flush_req during RUN with requests pending -> no grants for 256 cycles, sweep restarts at set 0, then pending requests are served.
REQ-037: reset pulsed at sweep pair (30,2) -> outputs zero during reset; after release lru_access_set = 0, way 0.
REQ-038: acc grants to set 7 way 1, then set 7 way 3 on consecutive cycles -> lru_update_way = 1 then 3 on the following cycles; a later fill on set 7 returns way 0.
